// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer
//   Packs 32-byte stream words into 64-byte SHA-256 blocks and appends the
//   FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length).
//   Emits an extra padding-only block when the marker/length do not fit.
//   first/last flags tell the compression core when to load the IV and when
//   the digest is valid.
//
// Ports
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   in_val_i/in_rdy_o   input word handshake
//   in_data_i           message word, byte 0 = [255:248]
//   in_last_i           final word of the message
//   in_bytes_m1_i       valid bytes minus one on the final word
//   blk_val_o/blk_rdy_i block handshake towards the core
//   blk_data_o          block, byte 0 = [511:504]
//   blk_first_o         first block of a message
//   blk_last_o          final block of a message
//   busy_o              message in progress
module sha256_block_sequencer #(
    parameter int SHA_IF_DATA_W  = 256,
    parameter int SHA_IF_BYTES_W = 5,
    parameter int SHA256_BLOCK_W = 512,
    parameter int LEN_W          = 61
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      in_val_i,
    output logic                      in_rdy_o,
    input  logic [SHA_IF_DATA_W-1:0]  in_data_i,
    input  logic                      in_last_i,
    input  logic [SHA_IF_BYTES_W-1:0] in_bytes_m1_i,
    output logic                      blk_val_o,
    input  logic                      blk_rdy_i,
    output logic [SHA256_BLOCK_W-1:0] blk_data_o,
    output logic                      blk_first_o,
    output logic                      blk_last_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {ST_FILL, ST_SEND, ST_SEND_PAD} state_t;

    state_t                    state_q;
    logic                      half_q;
    logic [LEN_W-1:0]          cnt_q;
    logic                      first_q;
    logic                      last_q;
    logic                      pad_pend_q;
    logic                      pad_mark_q;
    logic [SHA256_BLOCK_W-1:0] blk_q;

    logic [5:0]                n_d;
    logic [6:0]                u_d;
    logic [LEN_W-1:0]          cnt_d;
    logic [SHA256_BLOCK_W-1:0] blk_fill_d;

    // Message length in bits, big-endian 64-bit field.
    function automatic logic [63:0] len64(input logic [LEN_W-1:0] c);
        return 64'({c, 3'b000});
    endfunction

    // Padding-only block: marker at byte 0 only when the message ended
    // exactly on a block boundary.
    function automatic logic [SHA256_BLOCK_W-1:0] pad_block(input logic mark,
                                                            input logic [LEN_W-1:0] c);
        logic [SHA256_BLOCK_W-1:0] b;
        b = '0;
        if (mark) b[511:504] = 8'h80;
        b[63:0] = len64(c);
        return b;
    endfunction

    // Block contents after accepting the current input word, including
    // masking of stale bytes and in-block padding on the final word.
    always_comb begin
        n_d        = in_last_i ? 6'(in_bytes_m1_i) + 6'd1 : 6'd32;
        u_d        = {1'b0, half_q, 5'd0} + {1'b0, n_d};
        cnt_d      = cnt_q + LEN_W'(n_d);
        blk_fill_d = blk_q;
        for (int i = 0; i < 32; i++) begin
            if (half_q)
                blk_fill_d[255-8*i -: 8] = (!in_last_i || 6'(i) < n_d) ? in_data_i[255-8*i -: 8] : 8'h00;
            else
                blk_fill_d[511-8*i -: 8] = (!in_last_i || 6'(i) < n_d) ? in_data_i[255-8*i -: 8] : 8'h00;
        end
        if (in_last_i) begin
            // Clears bytes left over from the previous block as well.
            for (int i = 0; i < 64; i++) begin
                if (7'(i) >= u_d) blk_fill_d[511-8*i -: 8] = 8'h00;
                if (7'(i) == u_d) blk_fill_d[511-8*i -: 8] = 8'h80;
            end
            if (u_d <= 7'd55) blk_fill_d[63:0] = len64(cnt_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_FILL;
            half_q     <= 1'b0;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            pad_pend_q <= 1'b0;
            pad_mark_q <= 1'b0;
            blk_q      <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_val_i) begin
                        blk_q <= blk_fill_d;
                        cnt_q <= cnt_d;
                        if (!in_last_i) begin
                            if (!half_q) begin
                                half_q <= 1'b1;
                            end else begin
                                state_q    <= ST_SEND;
                                last_q     <= 1'b0;
                                pad_pend_q <= 1'b0;
                            end
                        end else begin
                            state_q <= ST_SEND;
                            if (u_d <= 7'd55) begin
                                last_q     <= 1'b1;
                                pad_pend_q <= 1'b0;
                            end else begin
                                last_q     <= 1'b0;
                                pad_pend_q <= 1'b1;
                                pad_mark_q <= (u_d == 7'd64);
                            end
                        end
                    end
                end
                ST_SEND: begin
                    if (blk_rdy_i) begin
                        first_q <= last_q;
                        half_q  <= 1'b0;
                        if (pad_pend_q) begin
                            state_q    <= ST_SEND_PAD;
                            pad_pend_q <= 1'b0;
                            blk_q      <= pad_block(pad_mark_q, cnt_q);
                        end else begin
                            state_q <= ST_FILL;
                            if (last_q) cnt_q <= '0;
                        end
                    end
                end
                ST_SEND_PAD: begin
                    if (blk_rdy_i) begin
                        cnt_q   <= '0;
                        first_q <= 1'b1;
                        state_q <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign in_rdy_o    = (state_q == ST_FILL);
    assign blk_val_o   = (state_q != ST_FILL);
    assign blk_data_o  = blk_q;
    assign blk_first_o = (state_q == ST_SEND) & first_q;
    assign blk_last_o  = (state_q == ST_SEND) ? last_q : (state_q == ST_SEND_PAD);
    assign busy_o      = (cnt_q != '0) | (state_q != ST_FILL);

endmodule
